mem_addr_sel: RTL

MEM_ADDR_SEL -- requirements
Module: mem_addr_sel

---
 rtl/mem_addr_sel.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mem_addr_sel.sv
// rtl/mem_addr_sel.sv - memory address source selector with request/ack handshake
//
// Purpose:
//   Selects one of NSRC address sources and validates the access. A bad select,
//   a reserved size or a misaligned address is rejected. An accepted access
//   latches the address and then waits for mem_ack, giving up after TIMEOUT
//   cycles. The outputs mem_req, busy, done and err depend on the state alone.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   src       in   NSRC*WIDTH flattened sources; source k at [k*WIDTH +: WIDTH]
//   sel       in   SELW source select
//   start     in   access request; sampled only in IDLE
//   size      in   2: 00 byte, 01 halfword, 10 word, 11 reserved
//   mem_ack   in   memory accepts the current request
//   addr      out  WIDTH registered address
//   mem_req   out  high while in REQ
//   busy      out  high outside IDLE
//   done      out  one-cycle completion pulse
//   err       out  one-cycle error pulse
//   err_code  out  2: 00 none, 01 bad select, 10 misaligned/reserved, 11 timeout

module mem_addr_sel #(
  parameter int WIDTH   = 32,
  parameter int NSRC    = 8,
  parameter int SELW    = 3,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NSRC*WIDTH-1:0]   src,
  input  logic [SELW-1:0]         sel,
  input  logic                    start,
  input  logic [1:0]              size,
  input  logic                    mem_ack,
  output logic [WIDTH-1:0]        addr,
  output logic                    mem_req,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [1:0]              err_code
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_DONE = 2'b10,
    S_ERR  = 2'b11
  } state_t;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_BAD_SEL = 2'b01;
  localparam logic [1:0] CODE_ALIGN   = 2'b10;
  localparam logic [1:0] CODE_TIMEOUT = 2'b11;

  // The last wait cycle that may still be followed by an ack.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  addr_q, addr_d;
  logic [1:0]        code_q, code_d;
  logic [7:0]        cnt_q, cnt_d;

  logic [WIDTH-1:0]  cand;
  logic              bad_sel;
  logic              bad_align;

  // Mux written as a loop so that an out-of-range select never indexes past src.
  always_comb begin
    cand = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (sel == SELW'(k)) cand = src[k*WIDTH +: WIDTH];
    end
  end

  assign bad_sel = (32'(sel) >= NSRC);

  always_comb begin
    bad_align = 1'b0;
    unique case (size)
      2'b00:   bad_align = 1'b0;
      2'b01:   bad_align = cand[0];
      2'b10:   bad_align = (cand[1:0] != 2'b00);
      default: bad_align = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (bad_sel) begin
            state_d = S_ERR;
            code_d  = CODE_BAD_SEL;
          end else if (bad_align) begin
            state_d = S_ERR;
            code_d  = CODE_ALIGN;
          end else begin
            state_d = S_REQ;
            addr_d  = cand;
            code_d  = CODE_NONE;
            cnt_d   = '0;
          end
        end
      end
      S_REQ: begin
        // An ack arriving in the expiry cycle still completes the access.
        if (mem_ack) begin
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
          code_d  = CODE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      code_q  <= CODE_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode the state register directly, so reset clears them at once.
  assign mem_req  = (state_q == S_REQ);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERR);
  assign addr     = addr_q;
  assign err_code = code_q;

endmodule
